// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
package fifo_arb_pkg;

  // Arbiter FSM: free round-robin arbitration, or a burst held by one owner.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, circularly.
// Shared by the write arbiter and the read-side scheduler.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin : pick
    int k;
    // NOTE: every output gets a default before the loop so no path can leave one unassigned and infer a latch.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional burst lock per requester, full/almostfull throttling, and routing of
// the FIFO's wr_ack/overflow back to the requester that owned each write.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            err_o,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          wr_ack,
  input  logic                          overflow,
  output logic [CNT_W-1:0]              ovf_cnt
);

  localparam int               IDX_W   = idx_w(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;

  // Ownership pipeline: own0 tags the write on wr_en, own1 tags the FIFO response.
  logic [IDX_W-1:0]   own0;
  logic [IDX_W-1:0]   own1;
  logic               v1;

  logic               space_ok;
  logic               grant_en;
  logic               beat;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] pick_req;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // Circular successor of a requester index.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // A write already on wr_en will consume the last free slot when almostfull is up.
  assign space_ok = !full && !(almostfull && wr_en);
  assign grant_en = space_ok && !rst;

  // While locked only the owner is eligible; otherwise everyone, starting at rr_ptr.
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    pick_req          = req_i;
    pick_ptr          = rr_ptr;
    if (state == LOCKED) begin
      pick_req = req_i & owner_mask;
      pick_ptr = owner;
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // The picker only reports requesters whose req_i is high, so a grant is always a beat.
  assign gnt_o = grant_en ? pick_onehot : '0;
  assign beat  = grant_en && pick_any;

  // Arbitration FSM and round-robin pointer; frozen while the FIFO has no room.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state  <= ARB;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (space_ok) begin
      case (state)
        ARB: begin
          if (beat) begin
            rr_ptr <= next_idx(pick_idx);
            if (lock_i[pick_idx]) begin
              state <= LOCKED;
              owner <= pick_idx;
            end
          end
        end
        LOCKED: begin
          if (beat) begin
            if (!lock_i[owner]) begin
              state  <= ARB;
              rr_ptr <= next_idx(owner);
            end
          end else if (!req_i[owner] && !lock_i[owner]) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Registered FIFO write port and the owner tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      data_in <= '0;
      own0    <= '0;
      own1    <= '0;
      v1      <= 1'b0;
    end else begin
      wr_en <= beat;
      if (beat) begin
        data_in <= data_i[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
        own0    <= pick_idx;
      end
      own1 <= own0;
      v1   <= wr_en;
    end
  end

  // One-cycle ack/err pulses steered to the owner of the write being answered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o <= '0;
      err_o <= '0;
    end else begin
      ack_o <= '0;
      err_o <= '0;
      if (v1) begin
        ack_o[own1] <= wr_ack;
        err_o[own1] <= overflow;
      end
    end
  end

  // Saturating count of every overflow pulse, owned or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (overflow && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: scoreboard of expected writes and
// owner responses, plus a small FIFO responder that answers each wr_en.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 16;
  localparam int CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct {
    int          due;
    logic [W-1:0] data;
  } wr_exp_t;

  typedef struct {
    int                 due;
    logic [NUM_REQ-1:0] oh;
  } rsp_exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_i = '0;
  logic [NUM_REQ-1:0]     lock_i = '0;
  logic [NUM_REQ*W-1:0]   data_i = '0;
  logic [NUM_REQ-1:0]     gnt_o;
  logic [NUM_REQ-1:0]     ack_o;
  logic [NUM_REQ-1:0]     err_o;
  logic                   wr_en;
  logic [W-1:0]           data_in;
  logic                   full = 1'b0;
  logic                   almostfull = 1'b0;
  logic                   wr_ack = 1'b0;
  logic                   overflow = 1'b0;
  logic [CNT_W-1:0]       ovf_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  wr_exp_t  exp_wr[$];
  rsp_exp_t exp_ack[$];
  rsp_exp_t exp_err[$];
  wr_exp_t  m_wr;
  rsp_exp_t m_rsp;

  // FIFO responder controls and its sampled copies.
  logic ovf_mode = 1'b0;
  logic ovf_raw  = 1'b0;
  logic pend     = 1'b0;
  logic pmode    = 1'b0;
  logic praw     = 1'b0;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_WIDTH (W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .data_i     (data_i),
    .gnt_o      (gnt_o),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .full       (full),
    .almostfull (almostfull),
    .wr_ack     (wr_ack),
    .overflow   (overflow),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: answers a write one cycle after wr_en, with ack or (on request) overflow.
  always @(negedge clk) begin
    pend  = wr_en;
    pmode = ovf_mode;
    praw  = ovf_raw;
  end

  always @(posedge clk) begin
    #1;
    wr_ack   = pend && !pmode;
    overflow = (pend && pmode) || praw;
  end

  // Scoreboard monitor: every cycle, writes and owner pulses must match what is due.
  always @(negedge clk) begin
    if (exp_wr.size() != 0 && exp_wr[0].due == cyc) begin
      m_wr = exp_wr.pop_front();
      vectors++;
      if (wr_en !== 1'b1 || data_in !== m_wr.data) begin
        miscompares++;
        $display("FAIL write @%0d: wr_en=%b data_in=%h, want wr_en=1 data_in=%h", cyc, wr_en, data_in, m_wr.data);
      end
    end else if (wr_en !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL write @%0d: unexpected wr_en=%b data_in=%h", cyc, wr_en, data_in);
    end

    if (exp_ack.size() != 0 && exp_ack[0].due == cyc) begin
      m_rsp = exp_ack.pop_front();
      vectors++;
      if (ack_o !== m_rsp.oh) begin
        miscompares++;
        $display("FAIL ack @%0d: ack_o=%b, want %b", cyc, ack_o, m_rsp.oh);
      end
    end else if (ack_o !== '0) begin
      vectors++;
      miscompares++;
      $display("FAIL ack @%0d: unexpected ack_o=%b", cyc, ack_o);
    end

    if (exp_err.size() != 0 && exp_err[0].due == cyc) begin
      m_rsp = exp_err.pop_front();
      vectors++;
      if (err_o !== m_rsp.oh) begin
        miscompares++;
        $display("FAIL err @%0d: err_o=%b, want %b", cyc, err_o, m_rsp.oh);
      end
    end else if (err_o !== '0) begin
      vectors++;
      miscompares++;
      $display("FAIL err @%0d: unexpected err_o=%b", cyc, err_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int k = 0; k < NUM_REQ; k++) data_i[k*W +: W] = base + W'(k * 16'h0111);
  endtask

  // Record the write and owner response a beat in the current cycle must produce.
  task automatic exp_beat(input logic [NUM_REQ-1:0] oh, input bit ovf);
    wr_exp_t  w;
    rsp_exp_t r;
    int       idx;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) if (oh[k]) idx = k;
    w.due  = cyc + 1;
    w.data = data_i[idx*W +: W];
    r.due  = cyc + 3;
    r.oh   = oh;
    exp_wr.push_back(w);
    if (ovf) exp_err.push_back(r);
    else     exp_ack.push_back(r);
  endtask

  task automatic apply_reset();
    step();
    rst        = 1'b1;
    req_i      = '0;
    lock_i     = '0;
    full       = 1'b0;
    almostfull = 1'b0;
    ovf_mode   = 1'b0;
    ovf_raw    = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_wr.delete();
    exp_ack.delete();
    exp_err.delete();
  endtask

  task automatic test_reset();
    req_i = 4'hF;
    set_data(16'h1000);
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (gnt_o !== '0 || wr_en !== 1'b0 || data_in !== '0 || ack_o !== '0 || err_o !== '0 || ovf_cnt !== '0) begin
        miscompares++;
        $display("FAIL reset_state: gnt=%b wr_en=%b data_in=%h ack=%b err=%b ovf_cnt=%0d, want all zero",
                 gnt_o, wr_en, data_in, ack_o, err_o, ovf_cnt);
      end
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (gnt_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL first_grant: gnt_o=%b, want 0001", gnt_o);
    end
    exp_beat(4'b0001, 1'b0);
    step();
    req_i = '0;
    repeat (5) step();
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] exp;
    apply_reset();
    set_data(16'h2000);
    req_i = 4'hF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp = 4'(1 << (i % NUM_REQ));
      vectors++;
      if (gnt_o !== exp) begin
        miscompares++;
        $display("FAIL fairness beat %0d: gnt_o=%b, want %b", i, gnt_o, exp);
      end
      exp_beat(exp, 1'b0);
      step();
    end
    req_i = '0;
    repeat (5) step();
  endtask

  task automatic test_throttle();
    logic [NUM_REQ-1:0] g_tab [10];
    logic               af_tab [10];
    logic               fl_tab [10];
    g_tab  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
    af_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    fl_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    set_data(16'h3000);
    req_i = 4'hF;
    for (int i = 0; i < 10; i++) begin
      almostfull = af_tab[i];
      full       = fl_tab[i];
      @(negedge clk);
      vectors++;
      if (gnt_o !== g_tab[i]) begin
        miscompares++;
        $display("FAIL throttle cycle %0d: gnt_o=%b, want %b (full=%b almostfull=%b)", i, gnt_o, g_tab[i], full, almostfull);
      end
      if (g_tab[i] != '0) exp_beat(g_tab[i], 1'b0);
      step();
    end
    req_i      = '0;
    almostfull = 1'b0;
    full       = 1'b0;
    repeat (5) step();
    @(negedge clk);
    vectors++;
    if (ovf_cnt !== '0) begin
      miscompares++;
      $display("FAIL throttle ovf_cnt: ovf_cnt=%0d, want 0", ovf_cnt);
    end
  endtask

  task automatic test_lock();
    logic [NUM_REQ-1:0] g_tab [6];
    logic [NUM_REQ-1:0] r_tab [6];
    logic [NUM_REQ-1:0] l_tab [6];
    g_tab = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    r_tab = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    l_tab = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    apply_reset();
    set_data(16'h4000);
    for (int i = 0; i < 6; i++) begin
      req_i  = r_tab[i];
      lock_i = l_tab[i];
      @(negedge clk);
      vectors++;
      if (gnt_o !== g_tab[i]) begin
        miscompares++;
        $display("FAIL lock beat %0d: gnt_o=%b, want %b", i, gnt_o, g_tab[i]);
      end
      exp_beat(g_tab[i], 1'b0);
      step();
    end
    req_i  = '0;
    lock_i = '0;
    repeat (5) step();
  endtask

  task automatic test_error();
    apply_reset();
    set_data(16'h5000);
    req_i = 4'b0100;
    @(negedge clk);
    vectors++;
    if (gnt_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL error grant: gnt_o=%b, want 0100", gnt_o);
    end
    exp_beat(4'b0100, 1'b1);
    step();
    req_i    = '0;
    ovf_mode = 1'b1;
    step();
    ovf_mode = 1'b0;
    step();
    @(negedge clk);
    vectors++;
    if (ovf_cnt !== CNT_W'(1)) begin
      miscompares++;
      $display("FAIL error ovf_cnt: ovf_cnt=%0d, want 1", ovf_cnt);
    end
    // Unowned overflow pulses: counted, never reported on err_o.
    step();
    ovf_raw = 1'b1;
    repeat (100) step();
    ovf_raw = 1'b0;
    repeat (3) step();
    @(negedge clk);
    vectors++;
    if (ovf_cnt !== CNT_W'(101)) begin
      miscompares++;
      $display("FAIL count_101: ovf_cnt=%0d, want 101", ovf_cnt);
    end
    step();
    ovf_raw = 1'b1;
    repeat (200) step();
    ovf_raw = 1'b0;
    repeat (3) step();
    @(negedge clk);
    vectors++;
    if (ovf_cnt !== CNT_MAX) begin
      miscompares++;
      $display("FAIL saturate: ovf_cnt=%0d, want %0d", ovf_cnt, CNT_MAX);
    end
    step();
    ovf_raw = 1'b1;
    repeat (3) step();
    ovf_raw = 1'b0;
    repeat (3) step();
    @(negedge clk);
    vectors++;
    if (ovf_cnt !== CNT_MAX) begin
      miscompares++;
      $display("FAIL no_wrap: ovf_cnt=%0d, want %0d", ovf_cnt, CNT_MAX);
    end
  endtask

  task automatic test_midop_reset();
    apply_reset();
    set_data(16'h6000);
    req_i = 4'b0001;
    @(negedge clk);
    vectors++;
    if (gnt_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL midop grant: gnt_o=%b, want 0001", gnt_o);
    end
    exp_beat(4'b0001, 1'b0);
    step();
    req_i = '0;
    step();
    // wr_en was high last cycle; its response is in flight and must be dropped.
    rst   = 1'b1;
    req_i = 4'hF;
    exp_ack.delete();
    @(negedge clk);
    vectors++;
    if (gnt_o !== '0) begin
      miscompares++;
      $display("FAIL midop gnt during reset: gnt_o=%b, want 0000", gnt_o);
    end
    step();
    @(negedge clk);
    vectors++;
    if (gnt_o !== '0 || wr_en !== 1'b0 || data_in !== '0 || ack_o !== '0 || err_o !== '0 || ovf_cnt !== '0) begin
      miscompares++;
      $display("FAIL midop outputs: gnt=%b wr_en=%b data_in=%h ack=%b err=%b ovf_cnt=%0d, want all zero",
               gnt_o, wr_en, data_in, ack_o, err_o, ovf_cnt);
    end
    step();
    rst   = 1'b0;
    req_i = '0;
    repeat (5) step();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_throttle();
    test_lock();
    test_error();
    test_midop_reset();
    repeat (6) step();
    vectors++;
    if (exp_wr.size() != 0 || exp_ack.size() != 0 || exp_err.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending writes=%0d acks=%0d errs=%0d, want 0 0 0",
               exp_wr.size(), exp_ack.size(), exp_err.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
